// File: rtl/proc_pkg.sv
// Shared definitions for the fetch sequencer slice.
//   - fsm_state_e : fetch FSM states (IDLE, RUN, DONE)
//   - COND_*      : br_cond encodings
//   - REL_OFF_W   : width of the signed relative branch offset
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_state_e;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_PAR    = 2'b11;

  localparam int unsigned REL_OFF_W = 8;

endpackage

// File: rtl/jump_lut.sv
// Software-loadable jump-target table.
//   clk_i      : clock, entries update on the rising edge
//   rst_i      : asynchronous active-high reset, clears every entry to 0
//   wr_en_i    : write strobe
//   wr_idx_i   : entry index to write
//   wr_data_i  : target value to write
//   rd_idx_i   : entry index to read
//   rd_data_o  : combinational read of the registered entry (pre-write value)
module jump_lut #(
  parameter int unsigned LUT_N = 4,
  parameter int unsigned D     = 12,
  localparam int unsigned IdxW = $clog2(LUT_N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [D-1:0]    wr_data_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic [D-1:0]    rd_data_o
);

  logic [D-1:0] mem_q [LUT_N];
  logic [D-1:0] mem_d [LUT_N];

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LUT_N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads the registered array, so a same-cycle write is not visible here.
  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch unit: program counter, run/done handshake, conditional absolute
// (table) and signed relative branches.
//   clk, reset          : clock and asynchronous active-high reset
//   req                 : start request, honoured in IDLE and DONE
//   lut_wr_*            : jump-table write port
//   br_en/br_abs/br_cond/br_sel/rel_off : branch controls for current instr
//   zero_q, pari_q      : registered ALU flags used by br_cond
//   halt_instr          : current instruction is HALT
//   br_call, ret        : return-stack push/pop (only with CALL_STACK_EN)
//   prog_ctr            : fetch address
//   run, done           : decoded from FSM state
//   stk_err             : sticky stack over/underflow flag
// Build option: define CALL_STACK_EN to add a STACK_D-deep return stack;
// otherwise br_call/ret are ignored and stk_err is 0.
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned D         = 12,
  parameter int unsigned LUT_N     = 4,
  parameter int unsigned HALT_ADDR = 128,
  parameter int unsigned STACK_D   = 4,
  localparam int unsigned IdxW     = $clog2(LUT_N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 lut_wr_en,
  input  logic [IdxW-1:0]      lut_wr_idx,
  input  logic [D-1:0]         lut_wr_data,
  input  logic                 br_en,
  input  logic                 br_abs,
  input  logic [1:0]           br_cond,
  input  logic [IdxW-1:0]      br_sel,
  input  logic [REL_OFF_W-1:0] rel_off,
  input  logic                 zero_q,
  input  logic                 pari_q,
  input  logic                 halt_instr,
  input  logic                 br_call,
  input  logic                 ret,
  output logic [D-1:0]         prog_ctr,
  output logic                 run,
  output logic                 done,
  output logic                 stk_err
);

  localparam logic [D-1:0] HaltPc = D'(HALT_ADDR);

  fsm_state_e   state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] pc_inc, pc_rel, lut_rd_data;
  logic         cond_true, taken;

  jump_lut #(
    .LUT_N (LUT_N),
    .D     (D)
  ) u_jump_lut (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (lut_wr_en),
    .wr_idx_i  (lut_wr_idx),
    .wr_data_i (lut_wr_data),
    .rd_idx_i  (br_sel),
    .rd_data_o (lut_rd_data)
  );

  // Modulo-2**D arithmetic: wrap falls out of the fixed width.
  assign pc_inc = pc_q + D'(1);
  assign pc_rel = pc_q + {{(D - REL_OFF_W){rel_off[REL_OFF_W-1]}}, rel_off};

  always_comb begin
    cond_true = 1'b0;
    unique case (br_cond)
      COND_ALWAYS: cond_true = 1'b1;
      COND_Z:      cond_true = zero_q;
      COND_NZ:     cond_true = ~zero_q;
      COND_PAR:    cond_true = pari_q;
      default:     cond_true = 1'b0;
    endcase
  end

  assign taken = br_en & cond_true;

`ifdef CALL_STACK_EN
  localparam int unsigned SpW  = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam int unsigned CntW = $clog2(STACK_D + 1);

  // Circular buffer: wr_q is the next free slot; when full it points at the
  // oldest entry, so a push overwrites exactly that one.
  logic [D-1:0]    stk_q [STACK_D];
  logic [D-1:0]    stk_d [STACK_D];
  logic [SpW-1:0]  wr_q, wr_d, wr_dec;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            stk_empty, stk_full;
  logic [D-1:0]    stk_top;
  logic            push_req, pop_req;

  assign stk_empty = (cnt_q == '0);
  assign stk_full  = (cnt_q == CntW'(STACK_D));
  assign wr_dec    = (wr_q == '0) ? SpW'(STACK_D - 1) : wr_q - SpW'(1);
  assign stk_top   = stk_q[wr_dec];

  always_comb begin
    stk_d = stk_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push_req) begin
      stk_d[wr_q] = pc_inc;
      wr_d        = (wr_q == SpW'(STACK_D - 1)) ? '0 : wr_q + SpW'(1);
      if (stk_full) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop_req) begin
      if (stk_empty) begin
        err_d = 1'b1;
      end else begin
        wr_d  = wr_dec;
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_D; i++) begin
        stk_q[i] <= '0;
      end
      wr_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign stk_err = err_q;
`else
  logic unused_stack;
  assign unused_stack = br_call ^ ret ^ (STACK_D == 0);
  assign stk_err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef CALL_STACK_EN
    push_req = 1'b0;
    pop_req  = 1'b0;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (req) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (halt_instr || (pc_q == HaltPc)) begin
          state_d = DONE;
`ifdef CALL_STACK_EN
        end else if (ret) begin
          pop_req = 1'b1;
          pc_d    = stk_empty ? pc_inc : stk_top;
`endif
        end else if (taken) begin
`ifdef CALL_STACK_EN
          push_req = br_call;
`endif
          pc_d = br_abs ? lut_rd_data : pc_rel;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign prog_ctr = pc_q;
  assign run      = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int D       = 12;
  localparam int LUT_N   = 4;
  localparam int HALT    = 128;
  localparam int STACK_D = 4;
  localparam int PCMOD   = 1 << D;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic         lut_wr_en;
  logic [1:0]   lut_wr_idx;
  logic [D-1:0] lut_wr_data;
  logic         br_en, br_abs;
  logic [1:0]   br_cond;
  logic [1:0]   br_sel;
  logic [7:0]   rel_off;
  logic         zero_q, pari_q, halt_instr, br_call, ret;
  logic [D-1:0] prog_ctr;
  logic         run, done, stk_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: mode 0 = idle, 1 = running, 2 = finished.
  int m_mode;
  int m_pc;
  int m_tab [LUT_N];
  int m_stk [$];
  bit m_err;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .D         (D),
    .LUT_N     (LUT_N),
    .HALT_ADDR (HALT),
    .STACK_D   (STACK_D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_idx  (lut_wr_idx),
    .lut_wr_data (lut_wr_data),
    .br_en       (br_en),
    .br_abs      (br_abs),
    .br_cond     (br_cond),
    .br_sel      (br_sel),
    .rel_off     (rel_off),
    .zero_q      (zero_q),
    .pari_q      (pari_q),
    .halt_instr  (halt_instr),
    .br_call     (br_call),
    .ret         (ret),
    .prog_ctr    (prog_ctr),
    .run         (run),
    .done        (done),
    .stk_err     (stk_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_pc   = 0;
    for (int i = 0; i < LUT_N; i++) m_tab[i] = 0;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_step();
    bit cond;
    cond = (br_cond == 2'd0) || (br_cond == 2'd1 && zero_q) ||
           (br_cond == 2'd2 && !zero_q) || (br_cond == 2'd3 && pari_q);
    if (m_mode == 1) begin
      if (halt_instr || m_pc == HALT) begin
        m_mode = 2;
`ifdef CALL_STACK_EN
      end else if (ret) begin
        if (m_stk.size() == 0) begin
          m_err = 1'b1;
          m_pc  = (m_pc + 1) % PCMOD;
        end else begin
          m_pc = m_stk.pop_back();
        end
`endif
      end else if (br_en && cond) begin
`ifdef CALL_STACK_EN
        if (br_call) begin
          m_stk.push_back((m_pc + 1) % PCMOD);
          if (m_stk.size() > STACK_D) begin
            void'(m_stk.pop_front());
            m_err = 1'b1;
          end
        end
`endif
        if (br_abs) m_pc = m_tab[br_sel];
        else m_pc = ((m_pc + int'($signed(rel_off))) % PCMOD + PCMOD) % PCMOD;
      end else begin
        m_pc = (m_pc + 1) % PCMOD;
      end
    end else if (req) begin
      m_mode = 1;
      m_pc   = 0;
    end
    // Table update after the read: same-cycle branch sees the old entry.
    if (lut_wr_en) m_tab[lut_wr_idx] = int'(lut_wr_data);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pc"},   32'(prog_ctr), 32'(m_pc));
    check({tag, ".run"},  32'(run),      32'(m_mode == 1));
    check({tag, ".done"}, 32'(done),     32'(m_mode == 2));
    check({tag, ".err"},  32'(stk_err),  32'(m_err));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic clr_in();
    req = 0; lut_wr_en = 0; lut_wr_idx = 0; lut_wr_data = 0;
    br_en = 0; br_abs = 0; br_cond = 0; br_sel = 0; rel_off = 0;
    zero_q = 0; pari_q = 0; halt_instr = 0; br_call = 0; ret = 0;
  endtask

  task automatic wr_tab(input int idx, input int val);
    lut_wr_en = 1; lut_wr_idx = 2'(idx); lut_wr_data = D'(val);
  endtask

  task automatic br_to(input int sel);
    br_en = 1; br_abs = 1; br_cond = 2'd0; br_sel = 2'(sel);
  endtask

  initial begin
    clr_in();
    reset = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: sequential run to the halt address
    req = 1; tick("t1.start");
    check("t1.first_pc", 32'(prog_ctr), 32'd0);
    req = 0;
    for (int i = 1; i <= HALT; i++) tick("t1.seq");
    check("t1.at_halt", 32'(prog_ctr), 32'd128);
    tick("t1.done");
    check("t1.done_hi", 32'(done), 32'd1);
    check("t1.run_lo", 32'(run), 32'd0);
    tick("t1.hold");
    check("t1.hold_pc", 32'(prog_ctr), 32'd128);

    // 2: absolute branch, same-cycle table write sees the old entry
    wr_tab(2, 'h040); tick("t2.wr");
    clr_in(); req = 1; tick("t2.req");
    clr_in();
    for (int i = 0; i < 3; i++) tick("t2.adv");
    br_to(2); wr_tab(2, 'h050); tick("t2.br");
    check("t2.old_tgt", 32'(prog_ctr), 32'h040);

    // 3: conditional relative branch
    clr_in(); wr_tab(0, 'h010); tick("t3.wr");
    clr_in(); br_to(0); tick("t3.to10");
    clr_in(); br_en = 1; rel_off = 8'hFC; br_cond = 2'd1; zero_q = 1; tick("t3.z1");
    check("t3.back4", 32'(prog_ctr), 32'h00C);
    clr_in(); br_en = 1; rel_off = 8'h04; tick("t3.fwd4");
    clr_in(); br_en = 1; rel_off = 8'hFC; br_cond = 2'd1; zero_q = 0; tick("t3.z0");
    check("t3.nottaken", 32'(prog_ctr), 32'h011);

    // 4: wrap-around
    clr_in(); wr_tab(1, 'hFFE); tick("t4.wr");
    clr_in(); br_to(1); tick("t4.toFFE");
    clr_in(); br_en = 1; rel_off = 8'd3; tick("t4.wrap");
    check("t4.wrap_pc", 32'(prog_ctr), 32'h001);
    check("t4.run", 32'(run), 32'd1);

    // 5: halt beats a taken branch, then restart
    clr_in(); wr_tab(3, 'h020); tick("t5.wr");
    clr_in(); br_to(3); tick("t5.to20");
    clr_in(); br_to(0); halt_instr = 1; tick("t5.halt");
    check("t5.halt_pc", 32'(prog_ctr), 32'h020);
    clr_in(); tick("t5.idle");
    req = 1; tick("t5.restart");
    check("t5.done_lo", 32'(done), 32'd0);

    // 6: asynchronous reset mid-run clears everything
    clr_in(); wr_tab(3, 'h035); tick("t6.wr");
    clr_in(); br_to(3); tick("t6.to35");
    clr_in();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6.async");
    check("t6.async_pc", 32'(prog_ctr), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req = 1; tick("t6.req");
    clr_in(); br_to(2); tick("t6.tab0");
    check("t6.tab_clr", 32'(prog_ctr), 32'd0);

`ifdef CALL_STACK_EN
    for (int i = 0; i < 5; i++) begin
      clr_in(); br_en = 1; rel_off = 8'd2; br_call = 1; tick("t6.call");
    end
    check("t6.overflow", 32'(stk_err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      clr_in(); ret = 1; tick("t6.ret");
    end
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      req         = ($urandom_range(0, 15) == 0);
      lut_wr_en   = ($urandom_range(0, 3) == 0);
      lut_wr_idx  = 2'($urandom_range(0, LUT_N - 1));
      lut_wr_data = D'($urandom);
      br_en       = ($urandom_range(0, 2) == 0);
      br_abs      = 1'($urandom);
      br_cond     = 2'($urandom);
      br_sel      = 2'($urandom_range(0, LUT_N - 1));
      rel_off     = 8'($urandom);
      zero_q      = 1'($urandom);
      pari_q      = 1'($urandom);
      halt_instr  = ($urandom_range(0, 40) == 0);
      br_call     = 1'($urandom);
      ret         = ($urandom_range(0, 5) == 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
